// File: rtl/des_pkg.sv
// DES permutation tables, S-box lookups, key schedule and FSM types.
// Shared by the DES encrypt and decrypt cores.
package des_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_DONE
    } state_t;

    // Right-rotation amounts for K16..K1 (reverse of the encrypt shifts)
    localparam int ROT [16] = '{0, 1, 2, 2, 2, 2, 2, 2,
                                1, 2, 2, 2, 2, 2, 2, 1};

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9,  1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41, 9,  49, 17, 57, 25};

    localparam int E_T [48] = '{
        32, 1,  2,  3,  4,  5,
        4,  5,  6,  7,  8,  9,
        8,  9,  10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32, 1};

    localparam int P_T [32] = '{
        16, 7,  20, 21, 29, 12, 28, 17,
        1,  15, 23, 26, 5,  18, 31, 10,
        2,  8,  24, 14, 32, 27, 3,  9,
        19, 13, 30, 6,  22, 11, 4,  25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9,
        1,  58, 50, 42, 34, 26, 18,
        10, 2,  59, 51, 43, 35, 27,
        19, 11, 3,  60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
        7,  62, 54, 46, 38, 30, 22,
        14, 6,  61, 53, 45, 37, 29,
        21, 13, 5,  28, 20, 12, 4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1,  5,
        3,  28, 15, 6,  21, 10,
        23, 19, 12, 4,  26, 8,
        16, 7,  27, 20, 13, 2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32};

    // One 256-bit row per box; entry (row*16+col) is a nibble, entry 0 at the MSB
    localparam logic [255:0] SBOX_T [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[63-i] = x[64-IP_T[i]];
        return o;
    endfunction

    function automatic logic [63:0] fp(input logic [63:0] x);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[63-i] = x[64-FP_T[i]];
        return o;
    endfunction

    function automatic logic [47:0] e_exp(input logic [31:0] x);
        logic [47:0] o;
        for (int i = 0; i < 48; i++) o[47-i] = x[32-E_T[i]];
        return o;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] o;
        for (int i = 0; i < 32; i++) o[31-i] = x[32-P_T[i]];
        return o;
    endfunction

    function automatic logic [55:0] pc1(input logic [63:0] x);
        logic [55:0] o;
        for (int i = 0; i < 56; i++) o[55-i] = x[64-PC1_T[i]];
        return o;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] x);
        logic [47:0] o;
        for (int i = 0; i < 48; i++) o[47-i] = x[56-PC2_T[i]];
        return o;
    endfunction

    function automatic logic [3:0] sbox(input int n, input logic [5:0] x);
        int idx;
        idx = int'({x[5], x[0], x[4:1]});
        return SBOX_T[n][255-4*idx -: 4];
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] v, input int n);
        logic [27:0] o;
        case (n)
            1:       o = {v[0], v[27:1]};
            2:       o = {v[1:0], v[27:2]};
            default: o = v;
        endcase
        return o;
    endfunction

    // 1 when any key byte fails odd parity
    function automatic logic key_par_bad(input logic [63:0] k);
        logic bad;
        bad = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (~^k[8*b+7 -: 8]) bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/des_f.sv
// DES round function f(R,K): expansion, key mix, S-boxes, P permutation.
// Purely combinational.
module des_f
    import des_pkg::*;
(
    input  logic [31:0] r,
    input  logic [47:0] k,
    output logic [31:0] f
);

    logic [47:0] x;
    logic [31:0] s;

    assign x = e_exp(r) ^ k;

    for (genvar g = 0; g < 8; g++) begin : g_sbox
        assign s[31-4*g -: 4] = sbox(g, x[47-6*g -: 6]);
    end

    assign f = p_perm(s);

endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption: one Feistel round per clock, subkeys
// produced K16..K1 by right-rotating the C/D halves.
module des_decrypt_core
    import des_pkg::*;
#(
    parameter bit CHECK_PARITY = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] ct,
    input  logic [63:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] pt,
    output logic        busy,
    output logic        key_par_err
);

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic [31:0] l, r;
    logic [27:0] c, d;
    logic [27:0] cs, ds;
    logic [47:0] rk;
    logic [31:0] fo;
    logic        acc;
    logic        last;

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);
    assign acc      = in_valid && in_ready;
    assign last     = (cnt == 4'd15);

    always_comb begin
        cs = rotr28(c, ROT[cnt]);
        ds = rotr28(d, ROT[cnt]);
        rk = pc2({cs, ds});
    end

    des_f u_f (
        .r (r),
        .k (rk),
        .f (fo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (in_valid) state_nx = S_ROUND;
            S_ROUND: if (last)     state_nx = S_DONE;
            S_DONE:  if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            l         <= '0;
            r         <= '0;
            c         <= '0;
            d         <= '0;
            pt        <= '0;
            out_valid <= 1'b0;
        end else begin
            if (acc) begin
                {l, r} <= ip(ct);
                {c, d} <= pc1(key);
                cnt    <= '0;
            end
            if (state == S_ROUND) begin
                l   <= r;
                r   <= l ^ fo;
                c   <= cs;
                d   <= ds;
                cnt <= cnt + 4'd1;
                // Final swap is undone by loading {R',L'} into FP
                if (last) begin
                    pt        <= fp({l ^ fo, r});
                    out_valid <= 1'b1;
                end
            end
            if (state == S_DONE && out_ready) out_valid <= 1'b0;
        end
    end

    if (CHECK_PARITY) begin : g_par
        logic par_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)   par_q <= 1'b0;
            else if (acc) par_q <= key_par_bad(key);
        end
        assign key_par_err = par_q;
    end else begin : g_nopar
        assign key_par_err = 1'b0;
    end

endmodule

// File: tb/tb_des_decrypt_core.sv
// Bench for des_decrypt_core: known-answer table plus handshake,
// busy-input, reset and parity corner cases, with a pt scoreboard.
module tb_des_decrypt_core;

    typedef struct {
        logic [63:0] key;
        logic [63:0] ct;
        logic [63:0] pt;
        logic        perr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] ct = '0;
    logic [63:0] key = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] pt;
    logic        busy;
    logic        key_par_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] sb[$];
    vec_t vt[4];

    always #5 clk = ~clk;

    des_decrypt_core #(.CHECK_PARITY(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ct          (ct),
        .key         (key),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pt          (pt),
        .busy        (busy),
        .key_par_err (key_par_err)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got timeout want event", nm);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) fail("unexpected_pt");
            else chk("pt", pt, sb.pop_front());
        end
    end

    // Returns just after the accept edge
    task automatic send(input logic [63:0] k, input logic [63:0] c,
                        input logic [63:0] p);
        int n = 0;
        @(posedge clk); #1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            fail("send_ready");
            return;
        end
        key = k;
        ct = c;
        in_valid = 1'b1;
        sb.push_back(p);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            fail("drain");
            sb.delete();
        end
    endtask

    initial begin
        int lat;
        int n;
        logic [63:0] p0;

        vt[0] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405,
                  64'h0123456789ABCDEF, 1'b0};
        vt[1] = '{64'h0E329232EA6D0D73, 64'h0000000000000000,
                  64'h8787878787878787, 1'b0};
        vt[2] = '{64'h133457799BBCDFF0, 64'h85E813540F0AB405,
                  64'h0123456789ABCDEF, 1'b1};
        vt[3] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405,
                  64'h0123456789ABCDEF, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pt", pt, 64'd0);
        chk("rst_par", 64'(key_par_err), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Known answers, latency and parity flag
        for (int i = 0; i < 4; i++) begin
            send(vt[i].key, vt[i].ct, vt[i].pt);
            @(negedge clk);
            chk("key_par_err", 64'(key_par_err), 64'(vt[i].perr));
            chk("busy_run", 64'(busy), 64'd1);
            lat = 1;
            while (!out_valid && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            chk("latency", 64'(lat), 64'd17);
            drain();
        end

        // Sink stalls for 5 cycles
        out_ready = 1'b0;
        send(vt[0].key, vt[0].ct, vt[0].pt);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail("stall_wait");
        p0 = pt;
        chk("stall_pt_val", p0, vt[0].pt);
        for (int i = 0; i < 5; i++) begin
            chk("stall_pt", pt, p0);
            chk("stall_ov", 64'(out_valid), 64'd1);
            chk("stall_rdy", 64'(in_ready), 64'd0);
            chk("stall_busy", 64'(busy), 64'd1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_hs_rdy", 64'(in_ready), 64'd1);
        chk("post_hs_busy", 64'(busy), 64'd0);
        chk("post_hs_ov", 64'(out_valid), 64'd0);
        chk("post_hs_pt", pt, vt[0].pt);
        drain();

        // New request presented while busy is ignored
        send(vt[0].key, vt[0].ct, vt[0].pt);
        @(posedge clk); #1;
        key = vt[1].key;
        ct = vt[1].ct;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("busy_in_rdy", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();
        send(vt[1].key, vt[1].ct, vt[1].pt);
        drain();

        // Reset mid-block abandons it
        send(vt[1].key, vt[1].ct, vt[1].pt);
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_ov", 64'(out_valid), 64'd0);
        chk("mid_rst_rdy", 64'(in_ready), 64'd1);
        chk("mid_rst_pt", pt, 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(vt[1].key, vt[1].ct, vt[1].pt);
        drain();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
